// File: rtl/spi_sram_slave.sv
// SPI slave front-end for the 256x8 SRAM array.
// It turns a command/address/data frame into SRAM strobes and returns read data on miso.
module spi_sram_slave #(
    parameter logic [7:0] CMD_WRITE = 8'h02,
    parameter logic [7:0] CMD_READ  = 8'h03
) (
    input  logic       sck,
    input  logic       rst_n,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic [7:0] sram_addr,
    output logic [7:0] sram_din,
    output logic       sram_we,
    output logic       sram_re,
    output logic       sram_ss,
    input  logic [7:0] sram_dout,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_WDATA  = 3'd3;
    localparam logic [2:0] ST_RDUMMY = 3'd4;
    localparam logic [2:0] ST_RDATA  = 3'd5;
    localparam logic [2:0] ST_IGNORE = 3'd6;

    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] out_sr_q, out_sr_d;
    logic [7:0] addr_cnt_q, addr_cnt_d;
    logic       rd_mode_q, rd_mode_d;
    logic       miso_q, miso_d;
    logic [7:0] sram_addr_q, sram_addr_d;
    logic [7:0] sram_din_q, sram_din_d;
    logic       sram_we_q, sram_we_d;
    logic       sram_re_q, sram_re_d;
    logic       sram_ss_q, sram_ss_d;
    logic       busy_q, busy_d;

    logic [7:0] byte_in;
    logic       byte_end;

    assign byte_in  = {shift_q[6:0], mosi};
    assign byte_end = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_sr_d    = out_sr_q;
        addr_cnt_d  = addr_cnt_q;
        rd_mode_d   = rd_mode_q;
        miso_d      = miso_q;
        sram_addr_d = sram_addr_q;
        sram_din_d  = sram_din_q;
        sram_we_d   = 1'b0;
        sram_re_d   = sram_re_q;
        sram_ss_d   = sram_ss_q;
        busy_d      = busy_q;

        if (ss) begin
            // Deselect discards any partial byte; addr/din simply hold.
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
            out_sr_d  = 8'h00;
            rd_mode_d = 1'b0;
            miso_d    = 1'b0;
            sram_re_d = 1'b0;
            sram_ss_d = 1'b1;
            busy_d    = 1'b0;
        end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = byte_in;
            case (state_q)
                ST_IDLE, ST_CMD: begin
                    state_d = ST_CMD;
                    if (byte_end) begin
                        if (byte_in == CMD_WRITE) begin
                            state_d   = ST_ADDR;
                            rd_mode_d = 1'b0;
                        end else if (byte_in == CMD_READ) begin
                            state_d   = ST_ADDR;
                            rd_mode_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_end) begin
                        sram_addr_d = byte_in;
                        addr_cnt_d  = byte_in;
                        sram_ss_d   = 1'b0;
                        busy_d      = 1'b1;
                        if (rd_mode_q) begin
                            sram_re_d = 1'b1;
                            state_d   = ST_RDUMMY;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (byte_end) begin
                        sram_din_d  = byte_in;
                        sram_addr_d = addr_cnt_q;
                        sram_we_d   = 1'b1;
                        addr_cnt_d  = addr_cnt_q + 8'd1;
                    end
                end
                ST_RDUMMY, ST_RDATA: begin
                    // Load the byte the SRAM is presenting and prefetch the next address.
                    if (byte_end) begin
                        out_sr_d    = sram_dout;
                        miso_d      = sram_dout[7];
                        sram_addr_d = addr_cnt_q + 8'd1;
                        addr_cnt_d  = addr_cnt_q + 8'd1;
                        state_d     = ST_RDATA;
                    end else if (state_q == ST_RDATA) begin
                        miso_d   = out_sr_q[6];
                        out_sr_d = {out_sr_q[6:0], 1'b0};
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            out_sr_q    <= 8'h00;
            addr_cnt_q  <= 8'h00;
            rd_mode_q   <= 1'b0;
            miso_q      <= 1'b0;
            sram_addr_q <= 8'h00;
            sram_din_q  <= 8'h00;
            sram_we_q   <= 1'b0;
            sram_re_q   <= 1'b0;
            sram_ss_q   <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_sr_q    <= out_sr_d;
            addr_cnt_q  <= addr_cnt_d;
            rd_mode_q   <= rd_mode_d;
            miso_q      <= miso_d;
            sram_addr_q <= sram_addr_d;
            sram_din_q  <= sram_din_d;
            sram_we_q   <= sram_we_d;
            sram_re_q   <= sram_re_d;
            sram_ss_q   <= sram_ss_d;
            busy_q      <= busy_d;
        end
    end

    assign miso      = miso_q;
    assign sram_addr = sram_addr_q;
    assign sram_din  = sram_din_q;
    assign sram_we   = sram_we_q;
    assign sram_re   = sram_re_q;
    assign sram_ss   = sram_ss_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_spi_sram_slave.sv
// Bench for spi_sram_slave: SRAM model, frame driver, reference memory and a scoreboard monitor.
module tb_spi_sram_slave;

    logic       sck = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] sram_addr;
    logic [7:0] sram_din;
    logic       sram_we;
    logic       sram_re;
    logic       sram_ss;
    logic [7:0] sram_dout = 8'h00;
    logic       busy;

    always #5 sck = ~sck;

    spi_sram_slave dut (
        .sck(sck), .rst_n(rst_n), .ss(ss), .mosi(mosi), .miso(miso),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we),
        .sram_re(sram_re), .sram_ss(sram_ss), .sram_dout(sram_dout), .busy(busy)
    );

    // Synchronous 256x8 SRAM; dout drops to 0 on enabled edges with no strobe.
    logic [7:0] mem [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_a = 8'h00;
    logic [7:0] pre_d = 8'h00;

    always @(posedge sck) begin
        if (pre_we) mem[pre_a] <= pre_d;
        else if (!sram_ss) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else if (sram_re) sram_dout <= mem[sram_addr];
            else sram_dout <= 8'h00;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] ref_mem [256];
    logic       bits_q[$];
    logic [7:0] dq[$];

    // Monitor: edge number n counts posedges with ss=0 since the last ss=1 posedge.
    int         mon_n = 0;
    logic [7:0] mon_cmd = 8'h00;
    logic [7:0] mon_rbyte = 8'h00;
    wr_t        mon_e;
    logic [7:0] mon_exp;

    always @(posedge sck) begin
        #1;
        if (!rst_n) begin
            mon_n = 0;
        end else if (ss) begin
            mon_n = 0;
            chk("idle_outs", 32'({miso, busy, sram_we, sram_re, sram_ss}), 32'h01);
        end else begin
            mon_n++;
            if (mon_n <= 8) mon_cmd = {mon_cmd[6:0], mosi};
            chk("we_re_excl", 32'(sram_we & sram_re), 32'h0);
            if (sram_we) begin
                if (wr_q.size() == 0) chk("spurious_we", 32'h1, 32'h0);
                else begin
                    mon_e = wr_q.pop_front();
                    chk("write", 32'({sram_ss, sram_addr, sram_din}), 32'({1'b0, mon_e.a, mon_e.d}));
                end
            end
            if (mon_n > 8 && mon_cmd != 8'h02 && mon_cmd != 8'h03)
                chk("ignore_outs", 32'({miso, busy, sram_we, sram_re, sram_ss}), 32'h01);
            if (mon_cmd == 8'h03 && mon_n >= 16)
                chk("rd_strobes", 32'({sram_re, sram_we, sram_ss, busy}), 32'h9);
            if (mon_cmd == 8'h02 && mon_n >= 16)
                chk("wr_strobes", 32'({sram_re, sram_ss, busy}), 32'h1);
            if (mon_cmd == 8'h03 && mon_n >= 24) begin
                mon_rbyte = {mon_rbyte[6:0], miso};
                if (((mon_n - 24) % 8) == 7) begin
                    if (rd_q.size() == 0) chk("spurious_read", 32'h1, 32'h0);
                    else begin
                        mon_exp = rd_q.pop_front();
                        chk("read_byte", 32'(mon_rbyte), 32'(mon_exp));
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bits_q.push_back(b[i]);
    endtask

    task automatic push_rand_bits(input int nb);
        for (int i = 0; i < nb; i++) bits_q.push_back(1'($urandom));
    endtask

    task automatic shift_bits();
        while (bits_q.size() > 0) begin
            @(negedge sck);
            ss = 1'b0;
            mosi = bits_q.pop_front();
        end
    endtask

    task automatic run_frame();
        shift_bits();
        @(negedge sck);
        ss = 1'b1;
        mosi = 1'($urandom);
        repeat (2) @(negedge sck);
    endtask

    // Burst write of the bytes in dq, followed by `extra` bits of an abandoned byte.
    task automatic do_write(input logic [7:0] a, input int extra);
        logic [7:0] ak;
        logic [7:0] d;
        wr_t e;
        push_byte(8'h02);
        push_byte(a);
        ak = a;
        while (dq.size() > 0) begin
            d = dq.pop_front();
            push_byte(d);
            ref_mem[ak] = d;
            e.a = ak;
            e.d = d;
            wr_q.push_back(e);
            ak = ak + 8'd1;
        end
        push_rand_bits(extra);
        run_frame();
    endtask

    task automatic do_read(input logic [7:0] a, input int nbytes, input int extra);
        logic [7:0] ak;
        push_byte(8'h03);
        push_byte(a);
        push_rand_bits(8 + 8 * nbytes + extra);
        ak = a;
        for (int k = 0; k < nbytes; k++) begin
            rd_q.push_back(ref_mem[ak]);
            ak = ak + 8'd1;
        end
        run_frame();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int mism;
        logic [7:0] a;
        int nb;
        int ex;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);

        // Reset held with ss low and mosi toggling; SRAM preloaded meanwhile.
        rst_n = 1'b0;
        ss = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge sck);
            pre_we = 1'b1;
            pre_a = 8'(i);
            pre_d = ref_mem[i];
            mosi = ~mosi;
            if (i == 40) chk("rst_outs_mid", 32'({miso, busy, sram_we, sram_re, sram_ss, sram_addr, sram_din}), 32'h10000);
        end
        @(negedge sck);
        pre_we = 1'b0;
        chk("rst_ctrl", 32'({miso, busy, sram_we, sram_re, sram_ss}), 32'h01);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_din", 32'(sram_din), 32'h0);
        rst_n = 1'b1;
        ss = 1'b1;
        repeat (2) @(negedge sck);
        chk("post_rst_idle", 32'({miso, busy, sram_we, sram_re, sram_ss}), 32'h01);

        // Single write
        dq = '{8'hA5};
        do_write(8'h3C, 0);
        chk("mem_3c", 32'(mem[8'h3C]), 32'hA5);

        // Burst read across the FF->00 wrap
        dq = '{8'h11};
        do_write(8'hFF, 0);
        dq = '{8'h22};
        do_write(8'h00, 0);
        do_read(8'hFF, 2, 0);

        // Burst write then readback
        dq = '{8'h01, 8'h02, 8'h03};
        do_write(8'h10, 0);
        chk("mem_10", 32'(mem[8'h10]), 32'h01);
        chk("mem_12", 32'(mem[8'h12]), 32'h03);
        do_read(8'h10, 3, 0);

        // Aborted write: only 5 data bits before deselect
        do_write(8'h20, 5);
        chk("mem_20_kept", 32'(mem[8'h20]), 32'(ref_mem[8'h20]));

        // Unknown command
        push_byte(8'h9F);
        push_rand_bits(24);
        run_frame();

        // Asynchronous reset in the middle of a read, after edge 28
        push_byte(8'h03);
        push_byte(8'h3C);
        push_rand_bits(12);
        shift_bits();
        @(posedge sck);
        #2;
        chk("busy_before_arst", 32'({busy, sram_re, sram_ss}), 32'h6);
        rst_n = 1'b0;
        #1;
        chk("arst_outs", 32'({miso, busy, sram_we, sram_re, sram_ss, sram_addr, sram_din}), 32'h10000);
        @(negedge sck);
        ss = 1'b1;
        @(negedge sck);
        rst_n = 1'b1;
        repeat (2) @(negedge sck);
        do_read(8'h3C, 1, 0);

        // Randomized frames
        for (int it = 0; it < 24; it++) begin
            a = 8'($urandom);
            nb = $urandom_range(1, 4);
            ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < nb; k++) dq.push_back(8'($urandom));
                do_write(a, ex);
            end else begin
                do_read(a, nb, ex);
            end
        end

        repeat (5) @(negedge sck);
        chk("wr_q_drained", 32'(wr_q.size()), 32'h0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_all", 32'(mism), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
